// File: rtl/sephirot_pkg.sv
// Shared types for the register file write scheduler: FSM state enum and
// a width helper that never returns zero for degenerate sizes.
package sephirot_pkg;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      CLEAR = 1'b1
   } wr_state_t;

   // Bits needed to index n items, at least 1 so vectors stay legal for n <= 1.
   function automatic int unsigned log2w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_conflict_picker.sv
// Combinational round-robin grant selection. Scans requesters starting at
// ptr_i, grants up to nWPORTS of them, skips any whose address collides with
// an earlier grant in the same scan, and reports which requester feeds each
// write port plus the pointer value for the next cycle.
module rr_conflict_picker
   import sephirot_pkg::*;
#(
   parameter int unsigned nREQ    = 4,
   parameter int unsigned nWPORTS = 2,
   parameter int unsigned AW      = 4,
   parameter int unsigned PW      = 2
) (
   input  logic [nREQ-1:0]       valid_i,
   input  logic [AW*nREQ-1:0]    addr_i,
   input  logic [PW-1:0]         ptr_i,
   output logic [nREQ-1:0]       grant_o,
   output logic [nWPORTS-1:0]    port_vld_o,
   output logic [nWPORTS*PW-1:0] port_sel_o,
   output logic [PW-1:0]         next_ptr_o
);

   logic [AW-1:0] addr_a [nREQ];
   int unsigned   idx;
   int unsigned   cnt;
   int unsigned   last;
   logic          hit;
   logic          any;

   for (genvar g = 0; g < nREQ; g++) begin : g_unpack
      assign addr_a[g] = addr_i[g*AW +: AW];
   end

   // Single scan in priority order; cnt is the port the next grant lands on.
   always_comb begin
      grant_o    = '0;
      port_vld_o = '0;
      port_sel_o = '0;
      idx        = 0;
      cnt        = 0;
      last       = 0;
      hit        = 1'b0;
      any        = 1'b0;
      for (int unsigned i = 0; i < nREQ; i++) begin
         idx = (32'(ptr_i) + i) % nREQ;
         if (valid_i[PW'(idx)] && (cnt < nWPORTS)) begin
            hit = 1'b0;
            for (int unsigned j = 0; j < nREQ; j++) begin
               if (grant_o[j] && (addr_a[j] == addr_a[PW'(idx)])) begin
                  hit = 1'b1;
               end
            end
            if (!hit) begin
               grant_o[PW'(idx)] = 1'b1;
               for (int unsigned p = 0; p < nWPORTS; p++) begin
                  if (p == cnt) begin
                     port_vld_o[p]          = 1'b1;
                     port_sel_o[p*PW +: PW] = PW'(idx);
                  end
               end
               cnt  = cnt + 1;
               last = idx;
               any  = 1'b1;
            end
         end
      end
      next_ptr_o = any ? PW'((last + 1) % nREQ) : ptr_i;
   end

endmodule

// File: rtl/regfile_wr_sched.sv
// Register file write scheduler: arbitrates nREQ write requesters onto
// nWPORTS registered write ports with a 1-cycle latency.
// Optional feature: define REGFILE_CLEAR_SWEEP_EN to build the CLEAR state,
// which zeroes the whole register file nWPORTS entries per cycle.
module regfile_wr_sched
   import sephirot_pkg::*;
#(
   parameter int unsigned MEMD    = 16,
   parameter int unsigned nREQ    = 4,
   parameter int unsigned nWPORTS = 2,
   parameter int unsigned DW      = 64
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [nREQ-1:0]                   req_valid,
   input  logic [log2w(MEMD)*nREQ-1:0]       req_addr,
   input  logic [DW*nREQ-1:0]                req_data,
   output logic [nREQ-1:0]                   req_ready,
   input  logic                              clear,
   output logic [nWPORTS-1:0]                WEnb,
   output logic [log2w(MEMD)*nWPORTS-1:0]    WAddr,
   output logic [DW*nWPORTS-1:0]             WData,
   output logic                              busy
);

   localparam int unsigned AW = log2w(MEMD);
   localparam int unsigned PW = log2w(nREQ);

   wr_state_t             state_q, state_d;
   logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
   logic [nWPORTS-1:0]    wenb_q, wenb_d;
   logic [AW*nWPORTS-1:0] waddr_q, waddr_d;
   logic [DW*nWPORTS-1:0] wdata_q, wdata_d;

   logic                  run;
   logic [nREQ-1:0]       pick_valid;
   logic [nREQ-1:0]       grant;
   logic [nWPORTS-1:0]    port_vld;
   logic [nWPORTS*PW-1:0] port_sel;
   logic [PW-1:0]         next_ptr;
   logic [AW-1:0]         addr_a [nREQ];
   logic [DW-1:0]         data_a [nREQ];

   for (genvar g = 0; g < nREQ; g++) begin : g_unpack
      assign addr_a[g] = req_addr[g*AW +: AW];
      assign data_a[g] = req_data[g*DW +: DW];
   end

   assign run        = (state_q == RUN);
   // Nothing is offered to the picker outside RUN, so the pointer holds there.
   assign pick_valid = run ? req_valid : '0;
   assign req_ready  = (run && !rst) ? grant : '0;

   rr_conflict_picker #(
      .nREQ    (nREQ),
      .nWPORTS (nWPORTS),
      .AW      (AW),
      .PW      (PW)
   ) u_picker (
      .valid_i    (pick_valid),
      .addr_i     (req_addr),
      .ptr_i      (rr_ptr_q),
      .grant_o    (grant),
      .port_vld_o (port_vld),
      .port_sel_o (port_sel),
      .next_ptr_o (next_ptr)
   );

`ifdef REGFILE_CLEAR_SWEEP_EN
   logic [AW-1:0] sweep_addr_q, sweep_addr_d;
   int unsigned   sw_a;

   assign busy = (state_q == CLEAR);

   // Sweep base address register; rst aborts any sweep in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         sweep_addr_q <= '0;
      end else begin
         sweep_addr_q <= sweep_addr_d;
      end
   end
`else
   logic unused_clear;

   assign unused_clear = clear;
   assign busy         = 1'b0;
`endif

   // Next state, pointer update and write-port staging.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      wenb_d   = '0;
      waddr_d  = '0;
      wdata_d  = '0;
`ifdef REGFILE_CLEAR_SWEEP_EN
      sweep_addr_d = sweep_addr_q;
      sw_a         = 0;
`endif
      case (state_q)
         RUN: begin
            rr_ptr_d = next_ptr;
            for (int unsigned k = 0; k < nWPORTS; k++) begin
               if (port_vld[k]) begin
                  wenb_d[k]            = 1'b1;
                  waddr_d[k*AW +: AW]  = addr_a[port_sel[k*PW +: PW]];
                  wdata_d[k*DW +: DW]  = data_a[port_sel[k*PW +: PW]];
               end
            end
`ifdef REGFILE_CLEAR_SWEEP_EN
            if (clear) begin
               state_d      = CLEAR;
               sweep_addr_d = '0;
            end
`endif
         end
`ifdef REGFILE_CLEAR_SWEEP_EN
         CLEAR: begin
            // Port k zeroes sweep_addr+k; ports past the end stay idle.
            for (int unsigned k = 0; k < nWPORTS; k++) begin
               sw_a = 32'(sweep_addr_q) + k;
               if (sw_a < MEMD) begin
                  wenb_d[k]           = 1'b1;
                  waddr_d[k*AW +: AW] = AW'(sw_a);
               end
            end
            if ((32'(sweep_addr_q) + nWPORTS) >= MEMD) begin
               state_d      = RUN;
               sweep_addr_d = '0;
            end else begin
               sweep_addr_d = AW'(32'(sweep_addr_q) + nWPORTS);
            end
         end
`endif
         default: state_d = RUN;
      endcase
   end

   // State, pointer and registered write-port outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= RUN;
         rr_ptr_q <= '0;
         wenb_q   <= '0;
         waddr_q  <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         wenb_q   <= wenb_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
      end
   end

   assign WEnb  = wenb_q;
   assign WAddr = waddr_q;
   assign WData = wdata_q;

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Directed bench for regfile_wr_sched: main instance with default parameters
// and a small MEMD=5 instance for the partial-sweep and abort cases.
// Clear-sweep checks follow REGFILE_CLEAR_SWEEP_EN.
module tb_regfile_wr_sched;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main instance: MEMD=16, nREQ=4, nWPORTS=2, DW=64.
   logic         rst;
   logic [3:0]   req_valid;
   logic [15:0]  req_addr;
   logic [255:0] req_data;
   logic [3:0]   req_ready;
   logic         clear;
   logic [1:0]   WEnb;
   logic [7:0]   WAddr;
   logic [127:0] WData;
   logic         busy;

   // Small instance: MEMD=5, nREQ=2, nWPORTS=2, DW=8.
   logic         rst_b;
   logic         clear_b;
   logic [1:0]   valid_b;
   logic [5:0]   addr_b;
   logic [15:0]  data_b;
   logic [1:0]   ready_b;
   logic [1:0]   wenb_b;
   logic [5:0]   waddr_b;
   logic [15:0]  wdata_b;
   logic         busy_b;

   int errors = 0;
   int checks = 0;

   regfile_wr_sched dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_ready (req_ready),
      .clear     (clear),
      .WEnb      (WEnb),
      .WAddr     (WAddr),
      .WData     (WData),
      .busy      (busy)
   );

   regfile_wr_sched #(
      .MEMD    (5),
      .nREQ    (2),
      .nWPORTS (2),
      .DW      (8)
   ) dut_b (
      .clk       (clk),
      .rst       (rst_b),
      .req_valid (valid_b),
      .req_addr  (addr_b),
      .req_data  (data_b),
      .req_ready (ready_b),
      .clear     (clear_b),
      .WEnb      (wenb_b),
      .WAddr     (waddr_b),
      .WData     (wdata_b),
      .busy      (busy_b)
   );

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] dat(input int i);
      return 64'hA5A5_0000_0000_0000 | 64'(i);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [3:0] v, input logic [3:0] a3, input logic [3:0] a2,
                          input logic [3:0] a1, input logic [3:0] a0);
      req_valid = v;
      req_addr  = {a3, a2, a1, a0};
      #1;
   endtask

   logic [7:0] exp_a;

   initial begin
      rst      = 1'b1;
      rst_b    = 1'b1;
      clear    = 1'b0;
      clear_b  = 1'b0;
      valid_b  = 2'b00;
      addr_b   = '0;
      data_b   = 16'h5A3C;
      req_data = {dat(3), dat(2), dat(1), dat(0)};
      set_req(4'b1111, 4'd4, 4'd3, 4'd2, 4'd1);
      chk("ready_in_rst", req_ready, 4'b0000);
      tick();
      tick();
      chk("ready_in_rst2", req_ready, 4'b0000);
      chk("wenb_rst", WEnb, 2'b00);
      chk("waddr_rst", WAddr, 8'h00);
      chk("wdata_rst", WData, 128'h0);
      chk("busy_rst", busy, 1'b0);
      chk("b_wenb_rst", wenb_b, 2'b00);
      chk("b_busy_rst", busy_b, 1'b0);

      // All valid, distinct addresses, pointer 0.
      rst   = 1'b0;
      rst_b = 1'b0;
      set_req(4'b1111, 4'd4, 4'd3, 4'd2, 4'd1);
      chk("rr_ready_p0", req_ready, 4'b0011);
      tick();
      chk("rr_wenb", WEnb, 2'b11);
      chk("rr_waddr", WAddr, 8'h21);
      chk("rr_wdata", WData, {dat(1), dat(0)});
      chk("rr_ready_p2", req_ready, 4'b1100);
      tick();
      chk("rr_waddr2", WAddr, 8'h43);
      chk("rr_wdata2", WData, {dat(3), dat(2)});

      // Address conflict between req0 and req1, pointer back at 0.
      set_req(4'b0111, 4'd0, 4'd6, 4'd5, 4'd5);
      chk("cf_ready", req_ready, 4'b0101);
      tick();
      chk("cf_wenb", WEnb, 2'b11);
      chk("cf_waddr", WAddr, 8'h65);
      chk("cf_wdata", WData, {dat(2), dat(0)});
      set_req(4'b0010, 4'd0, 4'd6, 4'd5, 4'd5);
      chk("cf_ready_held", req_ready, 4'b0010);
      tick();
      chk("cf_wenb_held", WEnb, 2'b01);
      chk("cf_waddr_held", WAddr[3:0], 4'd5);
      chk("cf_wdata_held", WData[63:0], dat(1));

      // Lone requester 3 repeatedly; pointer wraps to 0 and stays.
      for (int c = 0; c < 4; c++) begin
         set_req(4'b1000, 4'd9, 4'd0, 4'd0, 4'd0);
         chk("solo_ready", req_ready, 4'b1000);
         tick();
         chk("solo_wenb", WEnb, 2'b01);
         chk("solo_waddr", WAddr[3:0], 4'd9);
         chk("solo_wdata", WData[63:0], dat(3));
      end
      set_req(4'b1111, 4'd4, 4'd3, 4'd2, 4'd1);
      chk("solo_ptr0", req_ready, 4'b0011);
      tick();

      // Clear pulse together with a request from req0 (pointer at 2).
      clear = 1'b1;
      set_req(4'b0001, 4'd4, 4'd3, 4'd2, 4'd1);
      chk("clr_req_ready", req_ready, 4'b0001);
      tick();
      clear = 1'b0;
      chk("clr_req_wenb", WEnb, 2'b01);
      chk("clr_req_waddr", WAddr[3:0], 4'd1);
      set_req(4'b1111, 4'd4, 4'd3, 4'd2, 4'd1);
`ifdef REGFILE_CLEAR_SWEEP_EN
      for (int c = 0; c < 8; c++) begin
         clear = (c == 2);
         #1;
         chk("sw_busy", busy, 1'b1);
         chk("sw_ready", req_ready, 4'b0000);
         tick();
         exp_a = {4'(2 * c + 1), 4'(2 * c)};
         chk("sw_wenb", WEnb, 2'b11);
         chk("sw_waddr", WAddr, exp_a);
         chk("sw_wdata", WData, 128'h0);
      end
      clear = 1'b0;
      #1;
      chk("sw_done_busy", busy, 1'b0);
      chk("sw_done_ready", req_ready, 4'b0110);
`else
      chk("noclr_busy", busy, 1'b0);
      chk("noclr_ready", req_ready, 4'b0110);
`endif
      tick();
      chk("post_wenb", WEnb, 2'b11);
      chk("post_waddr", WAddr, 8'h32);
      chk("post_busy", busy, 1'b0);

      // Small instance: partial last sweep cycle, then reset mid-sweep.
`ifdef REGFILE_CLEAR_SWEEP_EN
      clear_b = 1'b1;
      tick();
      clear_b = 1'b0;
      chk("b_busy", busy_b, 1'b1);
      chk("b_wenb0", wenb_b, 2'b00);
      tick();
      chk("b_wenb1", wenb_b, 2'b11);
      chk("b_waddr1", waddr_b, {3'd1, 3'd0});
      tick();
      chk("b_wenb2", wenb_b, 2'b11);
      chk("b_waddr2", waddr_b, {3'd3, 3'd2});
      tick();
      chk("b_wenb3", wenb_b, 2'b01);
      chk("b_waddr3", waddr_b[2:0], 3'd4);
      chk("b_wdata3", wdata_b, 16'h0);
      chk("b_busy_done", busy_b, 1'b0);
      clear_b = 1'b1;
      tick();
      clear_b = 1'b0;
      tick();
      chk("b_abort_pre", wenb_b, 2'b11);
      rst_b = 1'b1;
      tick();
      chk("b_abort_wenb", wenb_b, 2'b00);
      chk("b_abort_busy", busy_b, 1'b0);
      rst_b = 1'b0;
      tick();
      chk("b_abort_wenb2", wenb_b, 2'b00);
      chk("b_abort_busy2", busy_b, 1'b0);
`else
      clear_b = 1'b1;
      tick();
      clear_b = 1'b0;
      chk("b_noclr_busy", busy_b, 1'b0);
      tick();
      chk("b_noclr_wenb", wenb_b, 2'b00);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
